// File: rtl/serial_subtractor_pkg.sv
// Package for the bit-serial subtractor slice.
// Holds the controller state encoding and the helper that sizes the
// bit-index counter from the operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the bit-index counter. A 1-bit operand would give $clog2 = 0,
  // so clamp to at least one bit to keep the port legal.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Interface bundling the start/busy/done handshake, the operands, the
// results and the display taps of serial_subtractor.
//
// Handshake: the controller raises start with a/b valid; the subtractor
// accepts it only in IDLE, and a and b are latched on that same edge. busy
// is high while bits are being resolved. done is a single-cycle pulse
// during which diff/borrow_out are valid. They stay valid until the next
// accepted start. A start seen while busy or done is dropped, not queued.
//
// Modports:
//   master : game controller (drives start/a/b, observes everything else)
//   slave  : serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  import serial_sub_pkg::*;

  localparam int IDX_W = idx_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic [IDX_W-1:0] bit_idx;
  logic             cur_borrow;
  state_t           state;      // controller state, exposed for debug

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, bit_idx, cur_borrow, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, bit_idx, cur_borrow, state
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell (a - b - bin), the subtract-direction twin
// of the full-adder teaching cell.
// Ports: a, b, bin (borrow in) -> d (difference bit), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they tie and a borrow came in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock through a single full_subtractor cell.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_subtractor_if slave: start/a/b in; busy, done, diff,
//          borrow_out, bit_idx, cur_borrow (borrow into bit_idx) and the
//          controller state out. All outputs are registered.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int IDX_W = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q,      state_n;
  logic [WIDTH-1:0] a_q,          a_n;
  logic [WIDTH-1:0] b_q,          b_n;
  logic [WIDTH-1:0] diff_q,       diff_n;
  logic             borrow_q,     borrow_n;
  logic             borrow_out_q, borrow_out_n;
  logic [IDX_W-1:0] idx_q,        idx_n;
  logic             busy_q,       busy_n;
  logic             done_q,       done_n;

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_n      = state_q;
    a_n          = a_q;
    b_n          = b_q;
    diff_n       = diff_q;
    borrow_n     = borrow_q;
    borrow_out_n = borrow_out_q;
    idx_n        = idx_q;
    busy_n       = 1'b0;
    done_n       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n  = SHIFT;
          a_n      = bus.a;
          b_n      = bus.b;
          diff_n   = '0;
          borrow_n = 1'b0;
          idx_n    = '0;
          busy_n   = 1'b1;
        end
      end
      SHIFT: begin
        diff_n[idx_q] = cell_d;
        borrow_n      = cell_bout;
        if (idx_q == LAST_IDX) begin
          state_n      = DONE;
          borrow_out_n = cell_bout;
          idx_n        = '0;
          done_n       = 1'b1;
        end else begin
          idx_n  = idx_q + IDX_W'(1);
          busy_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      a_q          <= a_n;
      b_q          <= b_n;
      diff_q       <= diff_n;
      borrow_q     <= borrow_n;
      borrow_out_q <= borrow_out_n;
      idx_q        <= idx_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.bit_idx    = idx_q;
  assign bus.cur_borrow = borrow_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): table of hand-computed
// vectors, hand-written sequences for held start and mid-run reset, and
// random operands checked against an arithmetic reference model.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bor;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors    = 0;
  int miscompares = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: borrow into bit k is 1 iff the low k bits of a, read as an
  // unsigned number, are smaller than the low k bits of b.
  function automatic logic ref_borrow_in(input logic [W-1:0] av,
                                         input logic [W-1:0] bv, input int k);
    logic [W:0] m;
    m = (W+1)'((1 << k) - 1);
    return ({1'b0, av} & m) < ({1'b0, bv} & m);
  endfunction

  function automatic logic [W-1:0] ref_low_diff(input logic [W-1:0] av,
                                                input logic [W-1:0] bv, input int k);
    logic [W-1:0] full;
    logic [W:0]   m;
    full = av - bv;
    m = (W+1)'((1 << k) - 1);
    return full & m[W-1:0];
  endfunction

  // ---------------- drivers ----------------
  // Issues one operation and checks it cycle by cycle. Sampling is on the
  // falling edge; negedge k is the one after rising edge E0+k.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b,
                        input bit scramble);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = av;
    bus_if.b     = bv;
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (scramble) begin
        bus_if.a = W'($urandom);
        bus_if.b = W'($urandom);
      end
      if (k < W) begin
        check("busy", 32'(bus_if.busy), 32'd1);
        check("done_low", 32'(bus_if.done), 32'd0);
        check("bit_idx", 32'(bus_if.bit_idx), 32'(k));
        check("cur_borrow", 32'(bus_if.cur_borrow), 32'(ref_borrow_in(av, bv, k)));
        check("partial_diff", 32'(bus_if.diff), 32'(ref_low_diff(av, bv, k)));
      end else if (k == W) begin
        check("done_pulse", 32'(bus_if.done), 32'd1);
        check("busy_off", 32'(bus_if.busy), 32'd0);
        check("bit_idx_wrap", 32'(bus_if.bit_idx), 32'd0);
        check("diff", 32'(bus_if.diff), 32'(exp_d));
        check("borrow_out", 32'(bus_if.borrow_out), 32'(exp_b));
      end else begin
        check("done_cleared", 32'(bus_if.done), 32'd0);
        check("idle_state", 32'(bus_if.state), 32'(IDLE));
        check("diff_held", 32'(bus_if.diff), 32'(exp_d));
        check("borrow_held", 32'(bus_if.borrow_out), 32'(exp_b));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, "_done"}, 32'(bus_if.done), 32'd0);
    check({tag, "_diff"}, 32'(bus_if.diff), 32'd0);
    check({tag, "_borrow_out"}, 32'(bus_if.borrow_out), 32'd0);
    check({tag, "_bit_idx"}, 32'(bus_if.bit_idx), 32'd0);
    check({tag, "_cur_borrow"}, 32'(bus_if.cur_borrow), 32'd0);
    check({tag, "_state"}, 32'(bus_if.state), 32'(IDLE));
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bor: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd10,  diff: 8'hFB,  bor: 1'b1};
    vecs[2] = '{a: 8'h00,  b: 8'h01,  diff: 8'hFF,  bor: 1'b1};
    vecs[3] = '{a: 8'hFF,  b: 8'hFF,  diff: 8'h00,  bor: 1'b0};
    vecs[4] = '{a: 8'h00,  b: 8'h00,  diff: 8'h00,  bor: 1'b0};
    vecs[5] = '{a: 8'h80,  b: 8'h7F,  diff: 8'h01,  bor: 1'b0};

    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Idle with start low must stay idle.
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", 32'(bus_if.busy), 32'd0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor, (i % 2) == 1);

    // start held high for a whole operation while a/b wander.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 8'd100;
    bus_if.b     = 8'd37;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      bus_if.a = W'($urandom);
      bus_if.b = W'($urandom);
      if (k == W) begin
        check("hold_done", 32'(bus_if.done), 32'd1);
        check("hold_diff", 32'(bus_if.diff), 32'd63);
        check("hold_borrow", 32'(bus_if.borrow_out), 32'd0);
        bus_if.a = 8'd9;
        bus_if.b = 8'd4;
      end else begin
        check("hold_busy", 32'(bus_if.busy), 32'd1);
      end
    end
    @(negedge clk);
    check("hold_back_idle_busy", 32'(bus_if.busy), 32'd0);
    check("hold_back_idle_done", 32'(bus_if.done), 32'd0);
    check("hold_back_idle_state", 32'(bus_if.state), 32'(IDLE));
    @(negedge clk);
    bus_if.start = 1'b0;
    check("hold_restart_busy", 32'(bus_if.busy), 32'd1);
    check("hold_restart_idx", 32'(bus_if.bit_idx), 32'd0);
    repeat (W) @(negedge clk);
    check("hold_second_done", 32'(bus_if.done), 32'd1);
    check("hold_second_diff", 32'(bus_if.diff), 32'd5);
    @(negedge clk);
    check("hold_second_idle", 32'(bus_if.state), 32'(IDLE));

    // Reset in the middle of an operation.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 8'h3C;
    bus_if.b     = 8'h5A;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_idx", 32'(bus_if.bit_idx), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b0;
    run_op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0);

    // Random operands against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = (n % 5 == 0) ? ra : W'($urandom_range(0, 255));
      run_op(ra, rb, ra - rb, ra < rb, n[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
